// File: rtl/accel_scratch_mem.sv
// Parametrised scratchpad: port-A read/write with write freeze, optional registered read,
// a hardware clear sweep (after reset and on request) and a sequential valid/ready dump port.
module accel_scratch_mem #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int READ_REG = 0
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  input  logic              getvalue,
  input  logic              clr,
  output logic              busy,
  input  logic              dump_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic [1:0]        dbg_state_o
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DUMP  = 2'd2
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_inc;
  logic              busy_q;
  logic              dump_valid_q;
  logic              dump_last_q;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign cnt_inc = cnt_q + ADDR_W'(1);

  // Dump handshake: a word moves when dump_valid && dump_ready are both high at a rising
  // edge; dump_valid never drops without a transfer except on clr or rst, and while
  // dump_ready is low dump_addr/dump_data hold.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state_q      <= S_CLEAR;
      cnt_q        <= '0;
      busy_q       <= 1'b1;
      dump_valid_q <= 1'b0;
      dump_last_q  <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (clr) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_IDLE: begin
          if (clr) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else if (dump_start) begin
            state_q      <= S_DUMP;
            cnt_q        <= '0;
            busy_q       <= 1'b1;
            dump_valid_q <= 1'b1;
            dump_last_q  <= 1'b0;
          end
        end
        S_DUMP: begin
          if (clr) begin
            state_q      <= S_CLEAR;
            cnt_q        <= '0;
            dump_valid_q <= 1'b0;
            dump_last_q  <= 1'b0;
          end else if (dump_ready) begin
            if (cnt_q == CNT_LAST) begin
              state_q      <= S_IDLE;
              cnt_q        <= '0;
              busy_q       <= 1'b0;
              dump_valid_q <= 1'b0;
              dump_last_q  <= 1'b0;
            end else begin
              cnt_q       <= cnt_inc;
              dump_last_q <= (cnt_inc == CNT_LAST);
            end
          end
        end
        default: begin
          state_q      <= S_CLEAR;
          cnt_q        <= '0;
          busy_q       <= 1'b1;
          dump_valid_q <= 1'b0;
          dump_last_q  <= 1'b0;
        end
      endcase
    end
  end

  // The sweep owns the write port while clearing; port-A writes are dropped then.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = addra;
    wr_data = dina;
    if (state_q == S_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = cnt_q;
      wr_data = '0;
    end else if (wea && !getvalue) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clka) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  generate
    if (READ_REG != 0) begin : g_rd_reg
      logic [DATA_W-1:0] douta_q;
      // Reads the pre-write array, so a same-edge write to addra returns old data.
      always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
          douta_q <= '0;
        end else if (ena && !getvalue) begin
          douta_q <= mem_q[addra];
        end
      end
      assign douta = douta_q;
    end else begin : g_rd_comb
      logic unused_ena;
      assign unused_ena = ena;
      assign douta      = mem_q[addra];
    end
  endgenerate

  assign busy        = busy_q;
  assign dump_valid  = dump_valid_q;
  assign dump_last   = dump_last_q;
  assign dump_addr   = cnt_q;
  assign dump_data   = mem_q[cnt_q];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_accel_scratch_mem.sv
// Bench for accel_scratch_mem: a default 64x32 combinational-read instance and a 16x8
// registered-read instance, both checked every cycle against a behavioural model.
module tb_accel_scratch_mem;

  localparam int DEPTH_A = 64;
  localparam int DEPTH_B = 16;

  logic clk;
  logic rst;

  // instance A: defaults
  logic        a_ena, a_wea, a_getvalue, a_clr, a_dump_start, a_dump_ready;
  logic [5:0]  a_addra, a_dump_addr;
  logic [31:0] a_dina, a_douta, a_dump_data;
  logic        a_busy, a_dump_valid, a_dump_last;
  logic [1:0]  a_dbg;

  // instance B: READ_REG=1, ADDR_W=4, DATA_W=8
  logic        b_ena, b_wea, b_getvalue, b_clr, b_dump_start, b_dump_ready;
  logic [3:0]  b_addra, b_dump_addr;
  logic [7:0]  b_dina, b_douta, b_dump_data;
  logic        b_busy, b_dump_valid, b_dump_last;
  logic [1:0]  b_dbg;

  accel_scratch_mem dut_a (
    .clka(clk), .rst(rst), .ena(a_ena), .wea(a_wea), .addra(a_addra), .dina(a_dina),
    .douta(a_douta), .getvalue(a_getvalue), .clr(a_clr), .busy(a_busy),
    .dump_start(a_dump_start), .dump_valid(a_dump_valid), .dump_ready(a_dump_ready),
    .dump_addr(a_dump_addr), .dump_data(a_dump_data), .dump_last(a_dump_last),
    .dbg_state_o(a_dbg)
  );

  accel_scratch_mem #(.DATA_W(8), .ADDR_W(4), .READ_REG(1)) dut_b (
    .clka(clk), .rst(rst), .ena(b_ena), .wea(b_wea), .addra(b_addra), .dina(b_dina),
    .douta(b_douta), .getvalue(b_getvalue), .clr(b_clr), .busy(b_busy),
    .dump_start(b_dump_start), .dump_valid(b_dump_valid), .dump_ready(b_dump_ready),
    .dump_addr(b_dump_addr), .dump_data(b_dump_data), .dump_last(b_dump_last),
    .dbg_state_o(b_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  int last_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A sweep is "cycles of clearing left"; a dump is "active flag + word index".
  int          ma_clr_left = DEPTH_A;
  bit          ma_dump = 1'b0;
  int          ma_idx = 0;
  logic [31:0] ma_mem [DEPTH_A];
  bit          wr_ok_a;

  int          mb_clr_left = DEPTH_B;
  bit          mb_dump = 1'b0;
  int          mb_idx = 0;
  logic [7:0]  mb_mem [DEPTH_B];
  logic [7:0]  mb_dout = 8'h00;
  bit          mb_dout_known = 1'b1;
  bit          wr_ok_b;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma_clr_left = DEPTH_A; ma_dump = 1'b0; ma_idx = 0;
      mb_clr_left = DEPTH_B; mb_dump = 1'b0; mb_idx = 0;
      mb_dout = 8'h00; mb_dout_known = 1'b1;
    end else begin
      wr_ok_a = (ma_clr_left == 0) && a_wea && !a_getvalue;
      if (ma_clr_left > 0) begin
        if (a_clr) ma_clr_left = DEPTH_A;
        else begin
          ma_clr_left--;
          if (ma_clr_left == 0) foreach (ma_mem[i]) ma_mem[i] = '0;
        end
      end else if (ma_dump) begin
        if (a_clr) begin ma_dump = 1'b0; ma_clr_left = DEPTH_A; end
        else if (a_dump_ready) begin
          if (ma_idx == DEPTH_A - 1) begin ma_dump = 1'b0; ma_idx = 0; end
          else ma_idx++;
        end
      end else begin
        if (a_clr) ma_clr_left = DEPTH_A;
        else if (a_dump_start) begin ma_dump = 1'b1; ma_idx = 0; end
      end
      if (wr_ok_a) ma_mem[a_addra] = a_dina;

      if (b_ena && !b_getvalue) begin
        mb_dout = mb_mem[b_addra];
        mb_dout_known = (mb_clr_left == 0);
      end
      wr_ok_b = (mb_clr_left == 0) && b_wea && !b_getvalue;
      if (mb_clr_left > 0) begin
        if (b_clr) mb_clr_left = DEPTH_B;
        else begin
          mb_clr_left--;
          if (mb_clr_left == 0) foreach (mb_mem[i]) mb_mem[i] = '0;
        end
      end else if (mb_dump) begin
        if (b_clr) begin mb_dump = 1'b0; mb_clr_left = DEPTH_B; end
        else if (b_dump_ready) begin
          if (mb_idx == DEPTH_B - 1) begin mb_dump = 1'b0; mb_idx = 0; end
          else mb_idx++;
        end
      end else begin
        if (b_clr) mb_clr_left = DEPTH_B;
        else if (b_dump_start) begin mb_dump = 1'b1; mb_idx = 0; end
      end
      if (wr_ok_b) mb_mem[b_addra] = b_dina;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("a_busy", 32'(a_busy), 32'((ma_clr_left > 0) || ma_dump));
    chk("a_dump_valid", 32'(a_dump_valid), 32'(ma_dump));
    chk("a_dump_addr", 32'(a_dump_addr),
        32'((ma_clr_left > 0) ? (DEPTH_A - ma_clr_left) : (ma_dump ? ma_idx : 0)));
    chk("a_dump_last", 32'(a_dump_last), 32'(ma_dump && (ma_idx == DEPTH_A - 1)));
    if (ma_clr_left == 0) chk("a_douta", a_douta, ma_mem[a_addra]);
    if (ma_dump) chk("a_dump_data", a_dump_data, ma_mem[ma_idx]);
    if (a_dump_valid && a_dump_ready && a_dump_last) last_seen++;
    if (a_dump_valid && a_dump_ready && exp_q.size() > 0)
      chk("a_dump_stream", a_dump_data, exp_q.pop_front());

    chk("b_busy", 32'(b_busy), 32'((mb_clr_left > 0) || mb_dump));
    chk("b_dump_valid", 32'(b_dump_valid), 32'(mb_dump));
    chk("b_dump_addr", 32'(b_dump_addr),
        32'((mb_clr_left > 0) ? (DEPTH_B - mb_clr_left) : (mb_dump ? mb_idx : 0)));
    chk("b_dump_last", 32'(b_dump_last), 32'(mb_dump && (mb_idx == DEPTH_B - 1)));
    if (mb_dout_known) chk("b_douta", 32'(b_douta), 32'(mb_dout));
    if (mb_dump) chk("b_dump_data", 32'(b_dump_data), 32'(mb_mem[mb_idx]));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (a_busy && n < 1000) begin
      step();
      n++;
    end
  endtask

  task automatic wait_addr(input int target);
    int n;
    n = 0;
    while (a_dump_addr != 6'(target) && n < 200) begin
      step();
      n++;
    end
    chk("dump_reach_addr", 32'(a_dump_addr), 32'(target));
  endtask

  // ---------------- stimulus ----------------
  int n;
  int nb;
  bit rdy;
  int pts[4] = '{0, 20, 40, 63};

  initial begin
    {a_ena, a_wea, a_getvalue, a_clr, a_dump_start, a_dump_ready} = '0;
    a_addra = '0; a_dina = '0;
    {b_ena, b_wea, b_getvalue, b_clr, b_dump_start, b_dump_ready} = '0;
    b_addra = '0; b_dina = '0;
    rst = 1'b1;
    step();
    step();
    chk("rst_busy", 32'(a_busy), 32'd1);
    chk("rst_dump_valid", 32'(a_dump_valid), 32'd0);
    chk("rst_dump_addr", 32'(a_dump_addr), 32'd0);
    chk("rst_b_douta", 32'(b_douta), 32'd0);
    rst = 1'b0;

    // post-reset sweeps: 64 cycles for A, 16 for B
    n = 0; nb = -1;
    while (a_busy && n < 1000) begin
      step();
      n++;
      if (!b_busy && nb < 0) nb = n;
    end
    chk("sweep_len_a", 32'(n), 32'd64);
    chk("sweep_len_b", 32'(nb), 32'd16);
    foreach (pts[i]) begin
      if (pts[i] != 20) begin
        a_addra = 6'(pts[i]);
        #1 chk("post_reset_read", a_douta, 32'h0);
      end
    end

    // getvalue blocks the write, then the write lands
    a_addra = 6'd5; a_dina = 32'hDEADBEEF; a_wea = 1'b1; a_getvalue = 1'b1;
    step();
    a_wea = 1'b0; a_getvalue = 1'b0;
    #1 chk("gv_blocked", a_douta, 32'h0);
    a_wea = 1'b1;
    step();
    a_wea = 1'b0;
    #1 chk("gv_written", a_douta, 32'hDEADBEEF);

    // registered read: read-first on same-edge write, then new data
    b_addra = 4'd3; b_dina = 8'h11; b_wea = 1'b1;
    step();
    b_dina = 8'hAA; b_ena = 1'b1;
    step();
    b_wea = 1'b0;
    chk("rr_old_data", 32'(b_douta), 32'h11);
    step();
    chk("rr_new_data", 32'(b_douta), 32'hAA);
    b_addra = 4'd4; b_getvalue = 1'b1; b_wea = 1'b1; b_dina = 8'h55;
    step();
    chk("rr_freeze_hold", 32'(b_douta), 32'hAA);
    b_getvalue = 1'b0; b_wea = 1'b0;
    step();
    chk("rr_freeze_nowrite", 32'(b_douta), 32'h00);
    b_ena = 1'b0;

    // fill and dump with dump_ready toggling
    for (int i = 0; i < DEPTH_A; i++) begin
      a_addra = 6'(i); a_dina = 32'h100 + 32'(i); a_wea = 1'b1;
      step();
    end
    a_wea = 1'b0;
    for (int i = 0; i < DEPTH_A; i++) exp_q.push_back(32'h100 + 32'(i));
    last_seen = 0;
    a_dump_start = 1'b1;
    step();
    a_dump_start = 1'b0;
    chk("dump_valid_rise", 32'(a_dump_valid), 32'd1);
    n = 0; rdy = 1'b1;
    while (a_busy && n < 1000) begin
      a_dump_ready = rdy;
      rdy = !rdy;
      step();
      n++;
    end
    a_dump_ready = 1'b0;
    chk("dump_cycles", 32'(n), 32'd127);
    chk("dump_drained", 32'(exp_q.size()), 32'd0);
    chk("dump_last_count", 32'(last_seen), 32'd1);

    // clr aborts a dump at addr 20; dump_start during the sweep is ignored
    a_dump_ready = 1'b1; a_dump_start = 1'b1;
    step();
    a_dump_start = 1'b0;
    wait_addr(20);
    a_clr = 1'b1;
    step();
    a_clr = 1'b0; a_dump_ready = 1'b0;
    chk("abort_valid_drop", 32'(a_dump_valid), 32'd0);
    n = 0;
    while (a_busy && n < 1000) begin
      a_dump_start = (n == 10);
      step();
      n++;
    end
    a_dump_start = 1'b0;
    chk("abort_sweep_len", 32'(n), 32'd64);
    chk("abort_no_dump", 32'(a_dump_valid), 32'd0);
    foreach (pts[i]) begin
      a_addra = 6'(pts[i]);
      #1 chk("abort_cleared", a_douta, 32'h0);
    end

    // asynchronous reset in the middle of a dump
    a_addra = 6'd9; a_dina = 32'h12345678; a_wea = 1'b1;
    step();
    a_wea = 1'b0;
    a_dump_ready = 1'b1; a_dump_start = 1'b1;
    step();
    a_dump_start = 1'b0;
    wait_addr(40);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(a_dump_valid), 32'd0);
    chk("arst_addr", 32'(a_dump_addr), 32'd0);
    chk("arst_busy", 32'(a_busy), 32'd1);
    step();
    rst = 1'b0; a_dump_ready = 1'b0;
    wait_idle(n);
    chk("arst_sweep_len", 32'(n), 32'd64);
    a_addra = 6'd9;
    #1 chk("arst_cleared", a_douta, 32'h0);

    // randomized traffic on both instances
    repeat (4000) begin
      a_ena        = 1'($urandom_range(0, 1));
      a_wea        = ($urandom_range(0, 2) == 0);
      a_addra      = ($urandom_range(0, 3) == 0) ? a_dump_addr : 6'($urandom_range(0, 63));
      a_dina       = $urandom;
      a_getvalue   = ($urandom_range(0, 4) == 0);
      a_clr        = ($urandom_range(0, 199) == 0);
      a_dump_start = ($urandom_range(0, 19) == 0);
      a_dump_ready = ($urandom_range(0, 3) != 0);
      b_ena        = 1'($urandom_range(0, 1));
      b_wea        = ($urandom_range(0, 2) == 0);
      b_addra      = ($urandom_range(0, 3) == 0) ? b_dump_addr : 4'($urandom_range(0, 15));
      b_dina       = 8'($urandom_range(0, 255));
      b_getvalue   = ($urandom_range(0, 4) == 0);
      b_clr        = ($urandom_range(0, 149) == 0);
      b_dump_start = ($urandom_range(0, 9) == 0);
      b_dump_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    {a_ena, a_wea, a_getvalue, a_clr, a_dump_start, a_dump_ready} = '0;
    {b_ena, b_wea, b_getvalue, b_clr, b_dump_start, b_dump_ready} = '0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
